// File: rtl/fpdiv_pkg.sv
// Shared definitions for the Goldschmidt divider: sequencer states, mux select codes,
// the initial-approximation constant and the state-to-control decode.
package fpdiv_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT_N  = 3'd1,
        INIT_D  = 3'd2,
        ITER_N  = 3'd3,
        ITER_D  = 3'd4,
        FINAL_N = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [1:0] MUXA_REGA = 2'b00;
    localparam logic [1:0] MUXA_D    = 2'b01;
    localparam logic [1:0] MUXA_IA   = 2'b10;

    localparam logic [1:0] MUXB_D    = 2'b00;
    localparam logic [1:0] MUXB_X    = 2'b01;
    localparam logic [1:0] MUXB_REGB = 2'b10;
    localparam logic [1:0] MUXB_REGC = 2'b11;

    localparam logic [23:0] IA_CONST = 24'h60_0000;

    typedef struct packed {
        logic [1:0] sel_muxa;
        logic [1:0] sel_muxb;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       busy;
        logic       done;
    } ctrl_out_t;

    // Moore decode: every control output is a pure function of the state.
    function automatic ctrl_out_t decode_state(input state_t st);
        ctrl_out_t o;
        o = '{sel_muxa: MUXA_REGA, sel_muxb: MUXB_D, loada: 1'b0, loadb: 1'b0,
              loadc: 1'b0, busy: 1'b1, done: 1'b0};
        case (st)
            IDLE:    o.busy = 1'b0;
            INIT_N:  begin o.sel_muxa = MUXA_IA;   o.sel_muxb = MUXB_X;    o.loadc = 1'b1; end
            INIT_D:  begin o.sel_muxa = MUXA_IA;   o.sel_muxb = MUXB_D;    o.loada = 1'b1; o.loadb = 1'b1; end
            ITER_N:  begin o.sel_muxa = MUXA_REGA; o.sel_muxb = MUXB_REGC; o.loadc = 1'b1; end
            ITER_D:  begin o.sel_muxa = MUXA_REGA; o.sel_muxb = MUXB_REGB; o.loada = 1'b1; o.loadb = 1'b1; end
            FINAL_N: begin o.sel_muxa = MUXA_REGA; o.sel_muxb = MUXB_REGC; o.loadc = 1'b1; end
            DONE:    o.done = 1'b1;
            default: o.busy = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/fpdiv_ctrl_if.sv
// Request/control bundle between a division requester, the sequencer and the fpdiv datapath.
interface fpdiv_ctrl_if;
    logic       start;
    logic       abort;
    logic [1:0] sel_muxa;
    logic [1:0] sel_muxb;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       busy;
    logic       done;

    modport master (
        input  start, abort,
        output sel_muxa, sel_muxb, loada, loadb, loadc, busy, done
    );

    modport slave (
        output start, abort,
        input  sel_muxa, sel_muxb, loada, loadb, loadc, busy, done
    );
endinterface

// File: rtl/fpdiv_ctrl.sv
// Goldschmidt divider sequencer: initial approximation pair, ITERS-1 refinement pairs,
// one final numerator multiply, then a single-cycle done pulse.
module fpdiv_ctrl
    import fpdiv_pkg::*;
#(
    parameter  int ITERS = 3,
    localparam int CNT_W = $clog2(ITERS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    fpdiv_ctrl_if.master  bus
);

    if ((ITERS < 1) || (ITERS > 7)) begin : g_iters_range
        $error("fpdiv_ctrl: ITERS must be within 1..7");
    end

    localparam logic [CNT_W:0]   ITERS_EXT = ITERS[CNT_W:0];
    localparam logic [CNT_W-1:0] CNT_MAX   = ITERS[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);

    state_t          state_r;
    state_t          state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic [CNT_W:0]   cnt_inc_s;
    ctrl_out_t        out_r;

    // Next-state and counter logic; abort overrides every transition.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        cnt_inc_s    = {1'b0, cnt_r} + {{CNT_W{1'b0}}, 1'b1};
        if (bus.abort) begin
            state_next_s = IDLE;
            cnt_next_s   = CNT_ZERO;
        end else begin
            case (state_r)
                IDLE:    if (bus.start) state_next_s = INIT_N; else state_next_s = IDLE;
                INIT_N:  state_next_s = INIT_D;
                INIT_D:  begin
                    cnt_next_s   = CNT_ONE;
                    state_next_s = (ITERS > 1) ? ITER_N : FINAL_N;
                end
                ITER_N:  state_next_s = ITER_D;
                ITER_D:  begin
                    // Saturate rather than wrap so a corrupted count can never re-enter the loop.
                    cnt_next_s   = (cnt_r < CNT_MAX) ? cnt_inc_s[CNT_W-1:0] : cnt_r;
                    state_next_s = (cnt_inc_s < ITERS_EXT) ? ITER_N : FINAL_N;
                end
                FINAL_N: state_next_s = DONE;
                DONE:    state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State, counter and outputs registered together; outputs decode the incoming state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            out_r   <= decode_state(IDLE);
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            out_r   <= decode_state(state_next_s);
        end
    end

    assign bus.sel_muxa = out_r.sel_muxa;
    assign bus.sel_muxb = out_r.sel_muxb;
    assign bus.loada    = out_r.loada;
    assign bus.loadb    = out_r.loadb;
    assign bus.loadc    = out_r.loadc;
    assign bus.busy     = out_r.busy;
    assign bus.done     = out_r.done;

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Scoreboard bench for fpdiv_ctrl with ITERS=3 and ITERS=1 instances driven by shared stimulus.
module tb_fpdiv_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fpdiv_ctrl_if ifa ();
    fpdiv_ctrl_if ifb ();

    fpdiv_ctrl #(.ITERS(3)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
    fpdiv_ctrl #(.ITERS(1)) dut_b (.clk(clk), .reset(reset), .bus(ifb));

    int total = 0;
    int bad   = 0;

    // {sel_muxa, sel_muxb, loada, loadb, loadc, busy, done}
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    int pos_a = -1;
    int pos_b = -1;

    logic hold_chk = 1'b0;
    int   last_done = -1;
    int   mcyc = 0;
    int   interval_checks = 0;
    logic [8:0] prev_a = 9'b0;
    logic [8:0] prev_b = 9'b0;

    localparam logic [8:0] O_IDLE   = {2'b00, 2'b00, 3'b000, 2'b00};
    localparam logic [8:0] O_INIT_N = {2'b10, 2'b01, 3'b001, 2'b10};
    localparam logic [8:0] O_INIT_D = {2'b10, 2'b00, 3'b110, 2'b10};
    localparam logic [8:0] O_NMUL   = {2'b00, 2'b11, 3'b001, 2'b10};
    localparam logic [8:0] O_DMUL   = {2'b00, 2'b10, 3'b110, 2'b10};
    localparam logic [8:0] O_DONE   = {2'b00, 2'b00, 3'b000, 2'b11};

    // Position in the schedule: -1 idle, 0 INIT_N, 1 INIT_D, pairs of N/D multiplies,
    // 2*iters the final N multiply, 2*iters+1 the done cycle.
    function automatic logic [8:0] model_out(input int pos, input int iters);
        if (pos < 0)              return O_IDLE;
        if (pos == 0)             return O_INIT_N;
        if (pos == 1)             return O_INIT_D;
        if (pos == 2 * iters)     return O_NMUL;
        if (pos == 2 * iters + 1) return O_DONE;
        if ((pos % 2) == 0)       return O_NMUL;
        return O_DMUL;
    endfunction

    function automatic int model_next(input int pos, input int iters,
                                      input logic r, input logic s, input logic a);
        if (r) return -1;
        if (a) return -1;
        if (pos < 0) return s ? 0 : -1;
        if (pos == 2 * iters + 1) return -1;
        return pos + 1;
    endfunction

    task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s sample=%0d actual=%b expected=%b", nm, mcyc, act, exp);
        end
    endtask

    task automatic chk_bit(input string nm, input logic ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL %s sample=%0d actual=violated expected=holds", nm, mcyc);
        end
    endtask

    task automatic invariants(input string nm, input logic [8:0] o, input logic [8:0] p);
        chk_bit({nm, "_muxa_not_11"}, o[8:7] != 2'b11);
        chk_bit({nm, "_loadb_loadc_excl"}, !(o[3] && o[2]));
        chk_bit({nm, "_loada_implies_loadb"}, !o[4] || o[3]);
        if (o[0]) chk_bit({nm, "_done_after_final"}, (p == O_NMUL));
    endtask

    // Scoreboard monitor: sample away from the rising edge and compare against the model queue.
    always @(negedge clk) begin
        logic [8:0] oa;
        logic [8:0] ob;
        oa = {ifa.sel_muxa, ifa.sel_muxb, ifa.loada, ifa.loadb, ifa.loadc, ifa.busy, ifa.done};
        ob = {ifb.sel_muxa, ifb.sel_muxb, ifb.loada, ifb.loadb, ifb.loadc, ifb.busy, ifb.done};
        if (qa.size() > 0) begin
            mcyc++;
            chk("ctrl_iters3", oa, qa.pop_front());
            chk("ctrl_iters1", ob, qb.pop_front());
            invariants("iters3", oa, prev_a);
            invariants("iters1", ob, prev_b);
            if (oa[0] && hold_chk) begin
                if (last_done >= 0) begin
                    interval_checks++;
                    total++;
                    if (mcyc - last_done != 9) begin
                        bad++;
                        $display("FAIL done_interval actual=%0d expected=9", mcyc - last_done);
                    end
                end
                last_done = mcyc;
            end
            prev_a = oa;
            prev_b = ob;
        end
    end

    task automatic step(input logic s, input logic a, input logic r);
        ifa.start = s; ifb.start = s;
        ifa.abort = a; ifb.abort = a;
        reset = r;
        @(posedge clk);
        pos_a = model_next(pos_a, 3, r, s, a);
        pos_b = model_next(pos_b, 1, r, s, a);
        qa.push_back(model_out(pos_a, 3));
        qb.push_back(model_out(pos_b, 1));
        #1;
    endtask

    initial begin
        ifa.start = 1'b0; ifb.start = 1'b0;
        ifa.abort = 1'b0; ifb.abort = 1'b0;
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        // Plain run.
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        // Start held high: back-to-back operations separated by one IDLE.
        last_done = -1;
        hold_chk = 1'b1;
        repeat (30) step(1'b1, 1'b0, 1'b0);
        hold_chk = 1'b0;
        repeat (10) step(1'b0, 1'b0, 1'b0);
        total++;
        if (interval_checks < 2) begin
            bad++;
            $display("FAIL done_interval_count actual=%0d expected>=2", interval_checks);
        end
        // Abort while in ITER_D, then a fresh run.
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        // Abort together with start in IDLE.
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        // Reset mid-operation, then a fresh run exercising the counter path.
        step(1'b1, 1'b0, 1'b0);
        repeat (2) step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        // Random start/abort/reset traffic.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 128) == 0);
        end
        repeat (12) step(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        total++;
        if (qa.size() != 0) begin
            bad++;
            $display("FAIL queue_drain actual=%0d expected=0", qa.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpdiv_ctrl.md
Name: fpdiv_ctrl

Overview:
- Control sequencer for the Goldschmidt floating-point divider datapath `fpdiv`. It sits directly upstream of `fpdiv` and drives `sel_muxa`, `sel_muxb`, `loada`, `loadb` and `loadc`.
- Accepts a start request and steps the datapath through the initial-approximation multiplies, then ITERS−1 refinement iteration pairs, then a final numerator multiply.
- Signals `done` when the quotient mantissa is valid in regc.
- Moore FSM plus an iteration counter; all outputs are decoded from the registered state.

Parameters:
- ITERS, default 3: total Goldschmidt refinement steps, legal range 1..7.
- CNT_W, default $clog2(ITERS+1): iteration counter width. Derived; not overridden.

Ports:
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  request a division; sampled only in IDLE
- abort  in  1  synchronous cancel; returns the FSM to IDLE
- sel_muxa  out  2  muxa select: 00=rega (K), 01=d, 10=IA constant; 11 is never driven
- sel_muxb  out  2  muxb select: 00=d, 01=x, 10=regb (D_i), 11=regc (N_i)
- loada  out  1  capture K = ones-complement of the product into rega
- loadb  out  1  capture the product into regb (denominator D_i)
- loadc  out  1  capture the product into regc (numerator N_i)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse; regc holds the quotient mantissa

Behaviour:
- States and outputs (sel_muxa, sel_muxb, loads):
  - IDLE: 00, 00, no loads.
  - INIT_N: 10, 01, loadc. N1 = IA·x.
  - INIT_D: 10, 00, loada+loadb. D1 = IA·d; K1 = ~D1.
  - ITER_N: 00, 11, loadc. N = K·N.
  - ITER_D: 00, 10, loada+loadb. D = K·D; K = ~D.
  - FINAL_N: 00, 11, loadc.
  - DONE: 00, 00, no loads; done=1.
- Transitions:
  - IDLE → INIT_N when start=1. Otherwise stay in IDLE.
  - INIT_N → INIT_D.
  - INIT_D → ITER_N when ITERS>1, else → FINAL_N. Counter cleared to 1.
  - ITER_N → ITER_D.
  - ITER_D → cnt+1; go to ITER_N if cnt+1 < ITERS, else → FINAL_N.
  - FINAL_N → DONE.
  - DONE → IDLE unconditionally. A start asserted during DONE is ignored.
- Ordering rule:
  - The N multiply always precedes the D multiply in each pair, so N uses K_i before ITER_D overwrites rega.
  - The final D multiply is never issued.
- Latency:
  - The datapath is active for 2·ITERS+1 cycles.
  - done is high in cycle 2·ITERS+2, counted from the clock edge that samples start (=8 for ITERS=3).
  - Throughput is one division per 2·ITERS+3 cycles. IDLE is mandatory between operations.
- start while busy: ignored; no queuing.
- abort:
  - Sampled in any non-IDLE state. Next state is IDLE, and all loads are 0 from the following cycle.
  - No done pulse is produced.
  - abort has priority over every transition, including DONE → IDLE (the result is same).
  - abort together with start in IDLE stays in IDLE.
- reset (priority over abort and start):
  - Next state IDLE, counter 0.
  - Outputs after the edge: sel_muxa=00, sel_muxb=00, all loads 0, busy=0, done=0.
  - Mid-operation reset behaves identically; register contents in `fpdiv` are left undefined.
- Output invariants:
  - sel_muxa never equals 11.
  - At most one of loadb/loadc is high in any cycle.
  - loada is high only together with loadb.
- Counter saturation:
  - The counter saturates at ITERS and never wraps.
  - Elaboration-time assertion fails if ITERS<1 or ITERS>7.

Decomposition:
- Package fpdiv_pkg holds:
  - the state enum (IDLE, INIT_N, INIT_D, ITER_N, ITER_D, FINAL_N, DONE);
  - MUXA_* constants: REGA=2'b00, D=2'b01, IA=2'b10;
  - MUXB_* constants: D=2'b00, X=2'b01, REGB=2'b10, REGC=2'b11;
  - the IA constant 24'h60_0000, shared with `fpdiv`.
- Single module; the counter is inline. No sub-module is warranted.

Test Plan:
- ITERS=3, reset then start pulse at cycle 0:
  - Cycles 1–7 are INIT_N, INIT_D, ITER_N, ITER_D, ITER_N, ITER_D, FINAL_N.
  - Per cycle, (sel_muxa, sel_muxb) = (10,01), (10,00), (00,11), (00,10), (00,11), (00,10), (00,11).
  - Loads are exactly as listed under Behaviour.
  - done=1 only at cycle 8; busy=1 on cycles 1–8.
- ITERS=1: start → INIT_N, INIT_D, FINAL_N, then done at cycle 4. ITER states are never entered.
- Hold start high continuously:
  - Second operation begins at cycle 10, i.e. IDLE at cycle 9.
  - done pulses are exactly 9 cycles apart.
- abort at cycle 4 (ITER_D):
  - Cycle 5 is IDLE with all loads 0, busy=0 and no done pulse.
  - A fresh start then completes normally.
- reset asserted at cycle 3:
  - From cycle 4, all outputs are at their reset values.
  - Counter is 0, checked by the next run's INIT_D → ITER_N path.
- Protocol assertions over 10k random start/abort cycles:
  - sel_muxa≠11.
  - loadb & loadc never both high.
  - loada implies loadb.
  - done is always one cycle wide and always preceded by FINAL_N.
